ormap_sequencer: RTL and testbench
==================================

ORMAP_SEQUENCER -- requirements
Module: ormap_sequencer

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 8, word-address width of the exe-env u32 store.
REQ-002 The block SHALL have the parameter LEN_W, default 9, width of the element count.
REQ-003 The block SHALL have the parameter FLAG_W, default 8, number of condition flags.
REQ-004 Port: clk  in  1  single clock; all logic rising-edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: cmd_valid  in  1  command offered.
REQ-007 Port: cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 Port: cmd_origin  in  ADDR_W  first destination/A word.
REQ-009 Port: cmd_modifier  in  ADDR_W  first B word.
REQ-010 Port: cmd_length  in  LEN_W  element count.
REQ-011 Port: cmd_cond_en  in  1  gate execution on a flag.
REQ-012 Port: cmd_flag_sel  in  $clog2(FLAG_W)  selected flag index.
REQ-013 Port: flags  in  FLAG_W  live condition flags.
REQ-014 Port: rd_en  out  1  read strobe for both read ports.
REQ-015 Port: rd_a_addr / rd_b_addr  out  ADDR_W each  read addresses.
REQ-016 Port: rd_a_data / rd_b_data  in  32 each  read data, valid the cycle after rd_en.
REQ-017 Port: wr_en, wr_addr (ADDR_W), wr_data (32)  out  single write port.
REQ-018 Port: busy  out  1  high in every state except IDLE.
REQ-019 Port: done  out  1  one-cycle pulse at command completion.
REQ-020 Port: skipped  out  1  one-cycle pulse with done when the condition failed.

Function
REQ-021 The FSM SHALL have states IDLE, CHECK, READ, WRITE, DONE.
REQ-022 IDLE: cmd_ready=1; on cmd_valid, the block SHALL latch origin, modifier, length, cond_en, flag_sel, clear index i, and go to CHECK.
REQ-023 CHECK: skip = cmd_cond_en && !flags[flag_sel], sampled this cycle; if skip or length==0 go to DONE, else READ.
REQ-024 READ: rd_en=1, rd_a_addr=origin+i, rd_b_addr=modifier+i; go to WRITE.
REQ-025 WRITE: wr_en=1, wr_addr=origin+i, wr_data=rd_a_data|rd_b_data; i++; go to DONE if i+1==length, else READ.
REQ-026 DONE: done=1, skipped=latched skip; go to IDLE; cmd_ready is 0 in DONE.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W (wrap, no error).
REQ-028 Latency: for length L>0, done SHALL assert exactly 2L+2 cycles after the accepting edge; for skip or L=0, 2 cycles.
REQ-029 Overlap: element i is read after element i-1 is written; results equal a pre-command snapshot OR whenever modifier>=origin or ranges are disjoint.
REQ-030 Command inputs and flags SHALL be ignored outside IDLE/CHECK respectively; no queuing.
REQ-031 rd_en, wr_en, done, skipped SHALL never assert in IDLE or CHECK.

Reset
REQ-032 rst SHALL force IDLE, i=0, and all outputs low except cmd_ready=1 in the following cycle.
REQ-033 rst mid-command SHALL abandon the command: no further writes, no done pulse.

Configuration
REQ-034 Macro ORMAP_SEQ_COND_EN defined: conditional gating per REQ-023.
REQ-035 Macro absent: cmd_cond_en, cmd_flag_sel, flags SHALL be ignored, skip constant 0, skipped tied low.

Verification
REQ-036 mem[4..6]=1,2,4, mem[10..12]=8,16,32; cmd origin=4, modifier=10, len=3, cond_en=0 -> mem[4..6]=9,18,36, done 8 cycles after accept, skipped=0.
REQ-037 cond_en=1, flag_sel=2, flags=8'h00, len=5 -> no wr_en, done+skipped 2 cycles after accept.
REQ-038 len=0 -> no rd_en/wr_en, done 2 cycles after accept, skipped=0.
REQ-039 ADDR_W=8, origin=8'hFE, modifier=8'h10, len=4 -> writes to FE, FF, 00, 01 in order.
REQ-040 rst asserted in second WRITE of a len=4 command -> exactly one write occurred, no done, cmd_ready=1 next cycle.
REQ-041 cmd_valid held high continuously -> back-to-back commands accepted only in IDLE, one done per command.

Source files
------------

// File: rtl/ormap_sequencer.sv
// ormap_sequencer: walks two u32 vectors in an external store and writes
// dst[i] = A[i] | B[i] back over the A vector, one element every two cycles.
// Optional feature: define ORMAP_SEQ_COND_EN to gate a whole command on a
// selected condition flag. Without it the flag inputs are unused and the
// command always runs.
module ormap_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9,
  parameter int FLAG_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_W-1:0]         cmd_origin,
  input  logic [ADDR_W-1:0]         cmd_modifier,
  input  logic [LEN_W-1:0]          cmd_length,
  input  logic                      cmd_cond_en,
  input  logic [$clog2(FLAG_W)-1:0] cmd_flag_sel,
  input  logic [FLAG_W-1:0]         flags,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_a_addr,
  output logic [ADDR_W-1:0]         rd_b_addr,
  input  logic [31:0]               rd_a_data,
  input  logic [31:0]               rd_b_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [31:0]               wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      skipped
);

  typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   i_q, i_d;
  logic               skip_q, skip_d;
  logic [ADDR_W-1:0]  origin_q, modifier_q;
  logic [LEN_W-1:0]   len_q;
  logic               accept;
  logic               skip_now;
  logic [ADDR_W-1:0]  idx;

  assign accept = (state_q == IDLE) && cmd_valid && !rst;
  assign idx    = ADDR_W'(i_q);
  assign busy   = (state_q != IDLE);

`ifdef ORMAP_SEQ_COND_EN
  logic                      cond_en_q;
  logic [$clog2(FLAG_W)-1:0] flag_sel_q;

  // Capture the gating controls together with the rest of the command.
  always_ff @(posedge clk) begin
    if (accept) begin
      cond_en_q  <= cmd_cond_en;
      flag_sel_q <= cmd_flag_sel;
    end
  end

  assign skip_now = cond_en_q && !flags[flag_sel_q];
`else
  logic unused_cond;
  assign unused_cond = ^{cmd_cond_en, cmd_flag_sel, flags};
  assign skip_now    = 1'b0;
`endif

  // Command operands are plain data: captured on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      origin_q   <= cmd_origin;
      modifier_q <= cmd_modifier;
      len_q      <= cmd_length;
    end
  end

  // Control state: FSM, element index and latched skip decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state and strobes; an asserted rst suppresses every strobe at once
  // so a reset landing mid-command cannot complete the write in flight.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    skip_d    = skip_q;
    cmd_ready = 1'b0;
    rd_en     = 1'b0;
    rd_a_addr = '0;
    rd_b_addr = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    done      = 1'b0;
    skipped   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid) begin
          i_d     = '0;
          skip_d  = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        skip_d = skip_now;
        if (skip_now || (len_q == '0)) state_d = DONE;
        else                          state_d = READ;
      end
      READ: begin
        rd_en     = !rst;
        rd_a_addr = origin_q + idx;
        rd_b_addr = modifier_q + idx;
        state_d   = WRITE;
      end
      WRITE: begin
        wr_en   = !rst;
        wr_addr = origin_q + idx;
        wr_data = rd_a_data | rd_b_data;
        i_d     = i_q + LEN_W'(1);
        if ((i_q + LEN_W'(1)) == len_q) state_d = DONE;
        else                            state_d = READ;
      end
      DONE: begin
        done    = !rst;
        skipped = skip_q && !rst;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ormap_sequencer.sv
// Directed bench for ormap_sequencer with a small two-read/one-write u32 store.
`timescale 1ns/1ps
module tb_ormap_sequencer;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 9;
  localparam int FLAG_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_origin, cmd_modifier;
  logic [LEN_W-1:0]  cmd_length;
  logic              cmd_cond_en;
  logic [2:0]        cmd_flag_sel;
  logic [FLAG_W-1:0] flags;
  logic              rd_en, wr_en, busy, done, skipped;
  logic [ADDR_W-1:0] rd_a_addr, rd_b_addr, wr_addr;
  logic [31:0]       rd_a_data, rd_b_data, wr_data;

  logic [31:0]       mem [0:255];
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, skip_cnt = 0, acc_cnt = 0, bad_cnt = 0;
  logic [ADDR_W-1:0] wlog [$];

  always #5 clk = ~clk;

  ormap_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_origin(cmd_origin), .cmd_modifier(cmd_modifier), .cmd_length(cmd_length),
    .cmd_cond_en(cmd_cond_en), .cmd_flag_sel(cmd_flag_sel), .flags(flags),
    .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .skipped(skipped)
  );

  // Store model: registered reads, one write port, plus a bench preload port.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a_data <= mem[rd_a_addr];
      rd_b_data <= mem[rd_b_addr];
    end
    if (ld_en)      mem[ld_addr] <= ld_data;
    else if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Event monitor, sampled mid low phase after stimulus has settled.
  always @(negedge clk) begin
    #3;
    if (rd_en === 1'b1) rd_cnt++;
    if (wr_en === 1'b1) begin wr_cnt++; wlog.push_back(wr_addr); end
    if (done === 1'b1) done_cnt++;
    if (skipped === 1'b1) skip_cnt++;
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) acc_cnt++;
    if (busy === 1'b0 && (rd_en === 1'b1 || wr_en === 1'b1 || done === 1'b1 || skipped === 1'b1)) bad_cnt++;
    if (busy === 1'b1 && cmd_ready === 1'b1) bad_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout reached without completion");
    $fatal(1);
  end

  task automatic mem_load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_cmd(input logic [ADDR_W-1:0] org, input logic [ADDR_W-1:0] modf,
                         input logic [LEN_W-1:0] len, input logic ce, input logic [2:0] sel,
                         input logic [FLAG_W-1:0] flg, input int exp_cyc, input logic exp_skip,
                         input string nm);
    int  cyc;
    bit  seen;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_origin = org; cmd_modifier = modf; cmd_length = len;
    cmd_cond_en = ce; cmd_flag_sel = sel; flags = flg;
    #2;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready got=%b want=1", nm, cmd_ready); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_origin = ~org; cmd_modifier = ~modf; cmd_length = len + 9'd3;
    cyc = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk); #2;
      cyc++;
      if (done === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen || cyc != exp_cyc) begin n_fail++; $display("FAIL %s_latency got=%0d seen=%0d want=%0d", nm, cyc, seen, exp_cyc); end
    n_checks++;
    if (skipped !== exp_skip) begin n_fail++; $display("FAIL %s_skipped got=%b want=%b", nm, skipped, exp_skip); end
    @(negedge clk); #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_origin = '0; cmd_modifier = '0; cmd_length = '0;
    cmd_cond_en = 1'b0; cmd_flag_sel = '0; flags = 8'hFF; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (rd_en !== 1'b0)     begin n_fail++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    n_checks++; if (wr_en !== 1'b0)     begin n_fail++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (skipped !== 1'b0)   begin n_fail++; $display("FAIL reset_skipped got=%b want=0", skipped); end
    n_checks++; if (wr_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_wr_addr got=%h want=00", wr_addr); end
  endtask

  task automatic test_basic();
    int w0;
    mem_load(8'd4, 32'd1);  mem_load(8'd5, 32'd2);  mem_load(8'd6, 32'd4);
    mem_load(8'd10, 32'd8); mem_load(8'd11, 32'd16); mem_load(8'd12, 32'd32);
    w0 = wr_cnt;
    run_cmd(8'd4, 8'd10, 9'd3, 1'b0, 3'd0, 8'hFF, 8, 1'b0, "basic");
    n_checks++; if (mem[4] !== 32'd9)  begin n_fail++; $display("FAIL basic_mem4 got=%0d want=9", mem[4]); end
    n_checks++; if (mem[5] !== 32'd18) begin n_fail++; $display("FAIL basic_mem5 got=%0d want=18", mem[5]); end
    n_checks++; if (mem[6] !== 32'd36) begin n_fail++; $display("FAIL basic_mem6 got=%0d want=36", mem[6]); end
    n_checks++; if (wr_cnt - w0 != 3)  begin n_fail++; $display("FAIL basic_writes got=%0d want=3", wr_cnt - w0); end
  endtask

  task automatic test_cond();
    int w0, r0, s0;
    w0 = wr_cnt; r0 = rd_cnt; s0 = skip_cnt;
`ifdef ORMAP_SEQ_COND_EN
    run_cmd(8'd60, 8'd70, 9'd5, 1'b1, 3'd2, 8'h00, 2, 1'b1, "cond_off");
    n_checks++; if (wr_cnt - w0 != 0)   begin n_fail++; $display("FAIL cond_off_writes got=%0d want=0", wr_cnt - w0); end
    n_checks++; if (rd_cnt - r0 != 0)   begin n_fail++; $display("FAIL cond_off_reads got=%0d want=0", rd_cnt - r0); end
    n_checks++; if (skip_cnt - s0 != 1) begin n_fail++; $display("FAIL cond_off_skips got=%0d want=1", skip_cnt - s0); end
`else
    run_cmd(8'd60, 8'd70, 9'd5, 1'b1, 3'd2, 8'h00, 12, 1'b0, "cond_off");
    n_checks++; if (wr_cnt - w0 != 5)   begin n_fail++; $display("FAIL cond_off_writes got=%0d want=5", wr_cnt - w0); end
    n_checks++; if (rd_cnt - r0 != 5)   begin n_fail++; $display("FAIL cond_off_reads got=%0d want=5", rd_cnt - r0); end
    n_checks++; if (skip_cnt - s0 != 0) begin n_fail++; $display("FAIL cond_off_skips got=%0d want=0", skip_cnt - s0); end
`endif
    mem_load(8'd30, 32'd16); mem_load(8'd31, 32'd1);
    run_cmd(8'd30, 8'd31, 9'd1, 1'b1, 3'd2, 8'h04, 4, 1'b0, "cond_on");
    n_checks++; if (mem[30] !== 32'd17) begin n_fail++; $display("FAIL cond_on_mem30 got=%0d want=17", mem[30]); end
  endtask

  task automatic test_len0();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    run_cmd(8'd50, 8'd51, 9'd0, 1'b0, 3'd0, 8'hFF, 2, 1'b0, "len0");
    n_checks++; if (wr_cnt - w0 != 0) begin n_fail++; $display("FAIL len0_writes got=%0d want=0", wr_cnt - w0); end
    n_checks++; if (rd_cnt - r0 != 0) begin n_fail++; $display("FAIL len0_reads got=%0d want=0", rd_cnt - r0); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a [4];
    logic [31:0]       exp_d [4];
    int base;
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_d = '{32'h101, 32'h202, 32'h404, 32'h808};
    mem_load(8'hFE, 32'h1); mem_load(8'hFF, 32'h2); mem_load(8'h00, 32'h4); mem_load(8'h01, 32'h8);
    mem_load(8'h10, 32'h100); mem_load(8'h11, 32'h200); mem_load(8'h12, 32'h400); mem_load(8'h13, 32'h800);
    base = wlog.size();
    run_cmd(8'hFE, 8'h10, 9'd4, 1'b0, 3'd0, 8'hFF, 10, 1'b0, "wrap");
    n_checks++; if (wlog.size() - base != 4) begin n_fail++; $display("FAIL wrap_count got=%0d want=4", wlog.size() - base); end
    for (int k = 0; k < 4; k++) begin
      if (base + k < wlog.size()) begin
        n_checks++;
        if (wlog[base + k] !== exp_a[k]) begin n_fail++; $display("FAIL wrap_addr%0d got=%h want=%h", k, wlog[base + k], exp_a[k]); end
      end
      n_checks++;
      if (mem[exp_a[k]] !== exp_d[k]) begin n_fail++; $display("FAIL wrap_data%0d got=%h want=%h", k, mem[exp_a[k]], exp_d[k]); end
    end
  endtask

  task automatic test_overlap();
    mem_load(8'd20, 32'd1); mem_load(8'd21, 32'd2); mem_load(8'd22, 32'd4); mem_load(8'd23, 32'd8);
    run_cmd(8'd20, 8'd21, 9'd3, 1'b0, 3'd0, 8'hFF, 8, 1'b0, "overlap");
    n_checks++; if (mem[20] !== 32'd3)  begin n_fail++; $display("FAIL overlap_mem20 got=%0d want=3", mem[20]); end
    n_checks++; if (mem[21] !== 32'd6)  begin n_fail++; $display("FAIL overlap_mem21 got=%0d want=6", mem[21]); end
    n_checks++; if (mem[22] !== 32'd12) begin n_fail++; $display("FAIL overlap_mem22 got=%0d want=12", mem[22]); end
    n_checks++; if (mem[23] !== 32'd8)  begin n_fail++; $display("FAIL overlap_mem23 got=%0d want=8", mem[23]); end
  endtask

  task automatic test_reset_mid();
    int w0, d0, base;
    mem_load(8'd80, 32'h1); mem_load(8'd81, 32'h2); mem_load(8'd82, 32'h4); mem_load(8'd83, 32'h8);
    mem_load(8'd90, 32'h10); mem_load(8'd91, 32'h20); mem_load(8'd92, 32'h40); mem_load(8'd93, 32'h80);
    w0 = wr_cnt; d0 = done_cnt; base = wlog.size();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_origin = 8'd80; cmd_modifier = 8'd90; cmd_length = 9'd4; cmd_cond_en = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b want=1", cmd_ready); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    repeat (12) @(negedge clk);
    #2;
    n_checks++; if (wr_cnt - w0 != 1)   begin n_fail++; $display("FAIL rstmid_writes got=%0d want=1", wr_cnt - w0); end
    n_checks++; if (done_cnt != d0)     begin n_fail++; $display("FAIL rstmid_done got=%0d want=%0d", done_cnt, d0); end
    n_checks++; if (mem[80] !== 32'h11) begin n_fail++; $display("FAIL rstmid_mem80 got=%h want=11", mem[80]); end
    n_checks++; if (mem[81] !== 32'h2)  begin n_fail++; $display("FAIL rstmid_mem81 got=%h want=2", mem[81]); end
    if (wlog.size() > base) begin
      n_checks++; if (wlog[base] !== 8'd80) begin n_fail++; $display("FAIL rstmid_addr got=%0d want=80", wlog[base]); end
    end
  endtask

  task automatic test_back_to_back();
    int a0, d0, w0;
    mem_load(8'd40, 32'd1); mem_load(8'd41, 32'd2);
    a0 = acc_cnt; d0 = done_cnt; w0 = wr_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_origin = 8'd40; cmd_modifier = 8'd41; cmd_length = 9'd1;
    cmd_cond_en = 1'b0; flags = 8'hFF;
    repeat (19) @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    n_checks++; if (acc_cnt - a0 != 4)  begin n_fail++; $display("FAIL b2b_accepts got=%0d want=4", acc_cnt - a0); end
    n_checks++; if (done_cnt - d0 != 4) begin n_fail++; $display("FAIL b2b_dones got=%0d want=4", done_cnt - d0); end
    n_checks++; if (wr_cnt - w0 != 4)   begin n_fail++; $display("FAIL b2b_writes got=%0d want=4", wr_cnt - w0); end
    n_checks++; if (mem[40] !== 32'd3)  begin n_fail++; $display("FAIL b2b_mem40 got=%0d want=3", mem[40]); end
  endtask

  task automatic test_protocol();
    n_checks++; if (bad_cnt != 0) begin n_fail++; $display("FAIL protocol_violations got=%0d want=0", bad_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cond();
    test_len0();
    test_wrap();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
